// File: rtl/id_scan_fsm.sv
// Identifier scanner: recognises letters-then-digits tokens in an ASCII char stream,
// tracking token length, overflow into an error state and a count of closed matches.
module id_scan_fsm #(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned ALLOW_US   = 0,
  parameter int unsigned LEN_W      = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic             char_valid,
  output logic             match,
  output logic             err,
  output logic [LEN_W-1:0] len,
  output logic [CNT_W-1:0] tok_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALPHA = 2'd1,
    DIGIT = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [3:0]         dcnt, dcnt_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               is_l, is_d, at_max, run_ok;

  always_comb begin
    is_l = ((char >= 8'h41) && (char <= 8'h5A)) ||
           ((char >= 8'h61) && (char <= 8'h7A)) ||
           ((ALLOW_US != 0) && (char == 8'h5F));
    is_d = (char >= 8'h30) && (char <= 8'h39);
  end

  assign at_max = (len_q == LEN_W'(MAX_LEN));
  assign run_ok = (dcnt >= 4'(MIN_DIGITS));

  always_comb begin
    state_n = state;
    len_n   = len_q;
    dcnt_n  = dcnt;
    cnt_n   = cnt_q;
    if (char_valid) begin
      unique case (state)
        IDLE: begin
          dcnt_n = '0;
          if (is_l) begin
            state_n = ALPHA;
            len_n   = LEN_W'(1);
          end else begin
            len_n   = '0;
          end
        end
        ALPHA, DIGIT: begin
          // Overflow wins over the normal letter/digit transitions.
          if ((is_l || is_d) && at_max) begin
            state_n = ERR;
            dcnt_n  = '0;
          end else if (is_d) begin
            state_n = DIGIT;
            len_n   = len_q + LEN_W'(1);
            if (state == ALPHA) dcnt_n = 4'd1;
            else if (dcnt != 4'd15) dcnt_n = dcnt + 4'd1;
          end else if (is_l) begin
            state_n = ALPHA;
            len_n   = len_q + LEN_W'(1);
            dcnt_n  = '0;
          end else begin
            if ((state == DIGIT) && run_ok) cnt_n = cnt_q + CNT_W'(1);
            state_n = IDLE;
            len_n   = '0;
            dcnt_n  = '0;
          end
        end
        ERR: begin
          if (is_l || is_d) begin
            len_n   = LEN_W'(MAX_LEN);
          end else begin
            state_n = IDLE;
            len_n   = '0;
            dcnt_n  = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      dcnt  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      len_q <= len_n;
      dcnt  <= dcnt_n;
      cnt_q <= cnt_n;
    end
  end

  assign match   = (state == DIGIT) && run_ok;
  assign err     = (state == ERR);
  assign len     = len_q;
  assign tok_cnt = cnt_q;

endmodule

// File: tb/tb_id_scan_fsm.sv
// Scoreboard bench for id_scan_fsm: five differently parameterised instances share one
// char stream; expected outputs are queued at drive time and popped after each edge.
module tb_id_scan_fsm;

  localparam int NI = 5;
  int P_MIN [NI] = '{1, 2, 1, 1, 1};
  int P_MAX [NI] = '{16, 16, 4, 16, 16};
  int P_US  [NI] = '{0, 0, 0, 1, 0};
  int P_CW  [NI] = '{8, 8, 8, 8, 2};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] char = 8'h20;
  logic       char_valid = 1'b0;

  logic       m0, m1, m2, m3, m4;
  logic       e0, e1, e2, e3, e4;
  logic [4:0] l0, l1, l3, l4;
  logic [2:0] l2;
  logic [7:0] c0, c1, c2, c3;
  logic [1:0] c4;

  always #5 clk = ~clk;

  id_scan_fsm u0 (.clk(clk), .reset(reset), .char(char), .char_valid(char_valid),
                  .match(m0), .err(e0), .len(l0), .tok_cnt(c0));
  id_scan_fsm #(.MIN_DIGITS(2)) u1 (.clk(clk), .reset(reset), .char(char),
                  .char_valid(char_valid), .match(m1), .err(e1), .len(l1), .tok_cnt(c1));
  id_scan_fsm #(.MAX_LEN(4), .LEN_W(3)) u2 (.clk(clk), .reset(reset), .char(char),
                  .char_valid(char_valid), .match(m2), .err(e2), .len(l2), .tok_cnt(c2));
  id_scan_fsm #(.ALLOW_US(1)) u3 (.clk(clk), .reset(reset), .char(char),
                  .char_valid(char_valid), .match(m3), .err(e3), .len(l3), .tok_cnt(c3));
  id_scan_fsm #(.CNT_W(2)) u4 (.clk(clk), .reset(reset), .char(char),
                  .char_valid(char_valid), .match(m4), .err(e4), .len(l4), .tok_cnt(c4));

  typedef struct {
    int    inst;
    int    match;
    int    err;
    int    len;
    int    cnt;
    string tag;
  } exp_t;

  exp_t q[$];
  int ntests = 0;
  int nfail  = 0;

  // Reference model state: 0 idle, 1 alpha, 2 digit, 3 err
  int ms [NI];
  int ml [NI];
  int md [NI];
  int mc [NI];

  task automatic chk(input string name, input int got, input int want);
    ntests++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  function automatic void model_step(input int i, input byte c, input bit v, input bit r);
    bit isl, isd;
    isl = (c >= 65 && c <= 90) || (c >= 97 && c <= 122) || (P_US[i] != 0 && c == 95);
    isd = (c >= 48 && c <= 57);
    if (r) begin
      ms[i] = 0; ml[i] = 0; md[i] = 0; mc[i] = 0;
    end else if (v) begin
      case (ms[i])
        0: begin
          if (isl) begin ms[i] = 1; ml[i] = 1; end
          else ml[i] = 0;
          md[i] = 0;
        end
        1, 2: begin
          if ((isl || isd) && ml[i] == P_MAX[i]) begin
            ms[i] = 3; md[i] = 0;
          end else if (isd) begin
            md[i] = (ms[i] == 1) ? 1 : ((md[i] < 15) ? md[i] + 1 : 15);
            ms[i] = 2; ml[i] = ml[i] + 1;
          end else if (isl) begin
            ms[i] = 1; ml[i] = ml[i] + 1; md[i] = 0;
          end else begin
            if (ms[i] == 2 && md[i] >= P_MIN[i]) mc[i] = (mc[i] + 1) % (1 << P_CW[i]);
            ms[i] = 0; ml[i] = 0; md[i] = 0;
          end
        end
        default: begin
          if (isl || isd) ml[i] = P_MAX[i];
          else begin ms[i] = 0; ml[i] = 0; md[i] = 0; end
        end
      endcase
    end
  endfunction

  task automatic get_obs(input int i, output int m, output int e, output int l, output int c);
    case (i)
      0: begin m = int'(m0); e = int'(e0); l = int'(l0); c = int'(c0); end
      1: begin m = int'(m1); e = int'(e1); l = int'(l1); c = int'(c1); end
      2: begin m = int'(m2); e = int'(e2); l = int'(l2); c = int'(c2); end
      3: begin m = int'(m3); e = int'(e3); l = int'(l3); c = int'(c3); end
      default: begin m = int'(m4); e = int'(e4); l = int'(l4); c = int'(c4); end
    endcase
  endtask

  task automatic drive(input byte c, input bit v, input bit r, input string tag);
    exp_t x;
    int om, oe, ol, oc;
    @(negedge clk);
    char = c; char_valid = v; reset = r;
    for (int i = 0; i < NI; i++) begin
      model_step(i, c, v, r);
      x.inst  = i;
      x.match = (ms[i] == 2 && md[i] >= P_MIN[i]) ? 1 : 0;
      x.err   = (ms[i] == 3) ? 1 : 0;
      x.len   = ml[i];
      x.cnt   = mc[i];
      x.tag   = tag;
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      get_obs(x.inst, om, oe, ol, oc);
      chk($sformatf("%s u%0d match", x.tag, x.inst), om, x.match);
      chk($sformatf("%s u%0d err", x.tag, x.inst), oe, x.err);
      chk($sformatf("%s u%0d len", x.tag, x.inst), ol, x.len);
      chk($sformatf("%s u%0d tok_cnt", x.tag, x.inst), oc, x.cnt);
    end
  endtask

  task automatic send(input string s, input string tag);
    for (int k = 0; k < s.len(); k++) drive(s[k], 1'b1, 1'b0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NI; i++) begin ms[i] = 0; ml[i] = 0; md[i] = 0; mc[i] = 0; end
    drive(8'h41, 1'b1, 1'b1, "reset");
    drive(8'h41, 1'b0, 1'b1, "reset2");

    send("ab12", "ab12");
    chk("ab12 u0 match const", int'(m0), 1);
    chk("ab12 u0 len const", int'(l0), 4);
    send(" ", "close1");
    chk("close1 u0 tok_cnt const", int'(c0), 1);

    send("x5 ", "x5");
    send("x55", "x55");
    chk("x55 u1 match const", int'(m1), 1);
    send(" ", "x55sp");
    chk("x55sp u1 len const", int'(l1), 0);

    send("abcde1", "ovf");
    chk("ovf u2 err const", int'(e2), 1);
    chk("ovf u2 len const", int'(l2), 4);
    send(" ", "ovfsp");

    send("a1", "hold");
    for (int k = 0; k < 3; k++) drive(8'h21, 1'b0, 1'b0, "novalid");
    chk("novalid u0 len const", int'(l0), 2);
    send(" ", "holdsp");

    send("_9", "us");
    chk("us u3 match const", int'(m3), 1);
    chk("us u0 len const", int'(l0), 0);
    send(" ", "ussp");

    send("12a3", "lead_d");
    send("a1b", "a1b");
    send("c22 ", "a1bc22");
    send("!! ", "seps");
    send("a123456789012345", "long16");
    send("6", "long17");
    send(" ", "longsp");
    send("a9999999999999999", "sat");
    send(" ", "satsp");

    send("ab1", "prerst");
    drive(8'h32, 1'b1, 1'b1, "rstmid");
    chk("rstmid u0 tok_cnt const", int'(c0), 0);

    for (int t = 0; t < 5; t++) send("a1 ", "wrap");
    chk("wrap u4 tok_cnt const", int'(c4), 1);
    send("z0", "tail");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/id_scan_fsm.md
Name: id_scan_fsm

Overview:
- Parametrised successor to the team's identifier-recognising FSM.
- Consumes one 8-bit ASCII char per valid cycle.
- Flags when the current token is letters followed by a run of digits, with a configurable minimum digit count and optional underscore-as-letter.
- Adds token length tracking, an overflow error state, and a running count of completed matching tokens; sits in the Pre-stage string-processing blocks.

Parameters:
- MIN_DIGITS, 1, number of trailing digits (1..15) required before match asserts.
- MAX_LEN, 16, maximum token length in chars (letters + digits); a longer token enters ERR.
- ALLOW_US, 0, when 1 '_' (8'h5F) is classed as a letter.
- LEN_W, 5, width of len output; must satisfy 2^LEN_W > MAX_LEN.
- CNT_W, 8, width of tok_cnt.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- char  input  8  ASCII character.
- char_valid  input  1  char is consumed on a posedge only when high.
- match  output  1  current token is letters-then-digits with digit run >= MIN_DIGITS.
- err  output  1  current token exceeded MAX_LEN.
- len  output  LEN_W  length of the current token, 0 when idle.
- tok_cnt  output  CNT_W  number of matching tokens closed by a separator.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high. Reset and every input are sampled on the posedge of clk.
- Char classes:
  - L: 'A'-'Z' (65-90) or 'a'-'z' (97-122), plus '_' when ALLOW_US=1.
  - D: '0'-'9' (48-57).
  - S: everything else.
- States: IDLE, ALPHA, DIGIT, ERR; encoded 2 bits, registered.
- Reset (reset=1 at posedge): state=IDLE, len=0, dcnt=0, tok_cnt=0. Resulting outputs: match=0, err=0. Reset has priority over char_valid, including mid-token; any partial token is discarded and tok_cnt is not incremented.
- char_valid=0: all registers hold.
- Transitions with char_valid=1:
  - IDLE: L -> ALPHA, len=1. D or S -> IDLE, len=0.
  - ALPHA: L -> ALPHA, len+1. D -> DIGIT, len+1, dcnt=1. S -> IDLE, len=0.
  - DIGIT: D -> DIGIT, len+1, dcnt+1 (saturating at 15). L -> ALPHA, len+1, dcnt=0 (token continues, e.g. "a1b"). S -> IDLE, len=0, dcnt=0.
  - ERR: L or D -> ERR, len holds at MAX_LEN. S -> IDLE, len=0.
- Overflow: in ALPHA or DIGIT, an L or D char when len==MAX_LEN goes to ERR instead; dcnt=0. Overflow takes precedence over the normal transition.
- tok_cnt: increments by 1 on an S char when state==DIGIT and dcnt>=MIN_DIGITS. It wraps modulo 2^CNT_W. No increment from ERR, ALPHA, or DIGIT with a short digit run.
- Outputs are decoded combinationally from registered state only:
  - match = (state==DIGIT) && (dcnt>=MIN_DIGITS).
  - err = (state==ERR).
  - Latency: a char sampled at posedge N is reflected in the outputs immediately after edge N. There is no char-to-output combinational path.
- A D char in IDLE does not start a token; "12a3" matches after the '3'.

Test Plan:
- Reset, then feed "ab12" with char_valid=1, MIN_DIGITS=1 -> match=0,0,1,1 after each edge; len=1,2,3,4.
- MIN_DIGITS=2, feed "x5 " -> match stays 0, tok_cnt stays 0. Feed "x55 " -> match=1 after the second '5', tok_cnt=1 after the space, len=0.
- MAX_LEN=4, feed "abcde1" -> err=1 from the 'e' edge onward, match=0, len=4. Feed ' ' -> err=0, state IDLE, tok_cnt unchanged.
- Feed "a1", drop char_valid for 3 cycles with char='!' -> match holds 1, len holds 2. Then valid ' ' -> tok_cnt increments by 1.
- ALLOW_US=1: "_9" -> match=1. ALLOW_US=0: "_9" -> match=0, len=0.
- Feed "ab1", assert reset with char='2' -> match=0, len=0, tok_cnt=0 next cycle. CNT_W=2: close 5 matching tokens -> tok_cnt=1 (wrap).
